// File: rtl/match_sequencer.sv
// Game-flow controller: sequences idle/serve/rally/point/pause/over, owns both scores.
// Build option WIN_BY_TWO_EN: a win also needs a two-point lead (31 always wins).
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | waiting for start, ball held at centre
// SERVE  | ball held, counting SERVE_FRAMES frame ticks
// PLAY   | rally in progress, goals and pause accepted
// POINT  | ball frozen after a point, counting PAUSE_FRAMES
// PAUSED | user pause, ball frozen where it stood
// OVER   | match finished, scores held until start
module match_sequencer #(
  parameter int WIN_SCORE    = 11,
  parameter int PAUSE_FRAMES = 60,
  parameter int SERVE_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       ball_en,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic [4:0] score1,
  output logic [4:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_POINT  = 3'd3,
    S_PAUSED = 3'd4,
    S_OVER   = 3'd5,
    S_RSVD6  = 3'd6,
    S_RSVD7  = 3'd7
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
  localparam logic [4:0] WIN        = 5'(WIN_SCORE);
  localparam logic [4:0] SCORE_MAX  = 5'd31;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, pause_q, arm_q;
  logic [4:0] score1_q, score1_d, score2_q, score2_d;
  logic       ball_en_q, ball_en_d, ball_rst_q, ball_rst_d;
  logic       serve_dir_q, serve_dir_d, game_over_q, game_over_d;
  logic       winner_q, winner_d;

  logic       start_e, pause_e;
  logic [4:0] s1_inc, s2_inc;
  logic       p1_wins, p2_wins;

  // arm_q masks the first clock after reset so a button held through reset gives no edge
  assign start_e = start_btn & ~start_q & arm_q;
  assign pause_e = pause_btn & ~pause_q & arm_q;

  assign s1_inc = (score1_q == SCORE_MAX) ? SCORE_MAX : score1_q + 5'd1;
  assign s2_inc = (score2_q == SCORE_MAX) ? SCORE_MAX : score2_q + 5'd1;

`ifdef WIN_BY_TWO_EN
  assign p1_wins = (s1_inc == SCORE_MAX) ||
                   ((s1_inc >= WIN) && ({1'b0, s1_inc} >= ({1'b0, score2_q} + 6'd2)));
  assign p2_wins = (s2_inc == SCORE_MAX) ||
                   ((s2_inc >= WIN) && ({1'b0, s2_inc} >= ({1'b0, score1_q} + 6'd2)));
`else
  assign p1_wins = (s1_inc == WIN);
  assign p2_wins = (s2_inc == WIN);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      arm_q       <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
      ball_en_q   <= 1'b0;
      ball_rst_q  <= 1'b1;
      serve_dir_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_btn;
      pause_q     <= pause_btn;
      arm_q       <= 1'b1;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      ball_en_q   <= ball_en_d;
      ball_rst_q  <= ball_rst_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    ball_en_d   = ball_en_q;
    ball_rst_d  = ball_rst_q;
    serve_dir_d = serve_dir_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    case (state_q)
      S_IDLE: begin
        ball_en_d  = 1'b0;
        ball_rst_d = 1'b1;
        if (start_e) begin
          score1_d    = '0;
          score2_d    = '0;
          serve_dir_d = 1'b0;
          state_d     = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d    = S_PLAY;
            ball_en_d  = 1'b1;
            ball_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (goal_p1 && goal_p2) begin
          state_d    = S_POINT;
          ball_en_d  = 1'b0;
          ball_rst_d = 1'b1;
        end else if (goal_p1) begin
          score1_d    = s1_inc;
          serve_dir_d = 1'b1;
          ball_en_d   = 1'b0;
          ball_rst_d  = 1'b1;
          if (p1_wins) begin
            state_d     = S_OVER;
            game_over_d = 1'b1;
            winner_d    = 1'b0;
          end else begin
            state_d = S_POINT;
          end
        end else if (goal_p2) begin
          score2_d    = s2_inc;
          serve_dir_d = 1'b0;
          ball_en_d   = 1'b0;
          ball_rst_d  = 1'b1;
          if (p2_wins) begin
            state_d     = S_OVER;
            game_over_d = 1'b1;
            winner_d    = 1'b1;
          end else begin
            state_d = S_POINT;
          end
        end else if (pause_e) begin
          state_d   = S_PAUSED;
          ball_en_d = 1'b0;
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          if (cnt_q == PAUSE_LAST) begin
            state_d = S_SERVE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PAUSED: begin
        ball_en_d = 1'b0;
        if (pause_e) begin
          state_d   = S_PLAY;
          ball_en_d = 1'b1;
        end
      end
      S_OVER: begin
        ball_en_d  = 1'b0;
        ball_rst_d = 1'b1;
        if (start_e) begin
          score1_d    = '0;
          score2_d    = '0;
          game_over_d = 1'b0;
          serve_dir_d = 1'b0;
          state_d     = S_SERVE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        ball_en_d  = 1'b0;
        ball_rst_d = 1'b1;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  assign ball_en   = ball_en_q;
  assign ball_rst  = ball_rst_q;
  assign serve_dir = serve_dir_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer with WIN_SCORE=3, PAUSE_FRAMES=2, SERVE_FRAMES=2.
// Expected output words are queued as stimulus is applied and drained per scenario.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       rst, frame_tick, start_btn, pause_btn, goal_p1, goal_p2;
  logic       ball_en, ball_rst, serve_dir, game_over, winner;
  logic [4:0] score1, score2;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  string       tag_q[$];
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  match_sequencer #(.WIN_SCORE(3), .PAUSE_FRAMES(2), .SERVE_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .goal_p1(goal_p1), .goal_p2(goal_p2),
    .ball_en(ball_en), .ball_rst(ball_rst), .serve_dir(serve_dir),
    .score1(score1), .score2(score2), .game_over(game_over),
    .winner(winner), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {state, score1, score2, ball_en, ball_rst, serve_dir, game_over, winner}
  function automatic logic [17:0] ev(input int st, input int s1, input int s2, input int en,
                                     input int rs, input int dir, input int go, input int w);
    return {3'(st), 5'(s1), 5'(s2), 1'(en), 1'(rs), 1'(dir), 1'(go), 1'(w)};
  endfunction

  function automatic logic [17:0] snap();
    return {state_o, score1, score2, ball_en, ball_rst, serve_dir, game_over, winner};
  endfunction

  task automatic push(input string t, input logic [17:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
    obs_q.push_back(snap());
  endtask

  task automatic cyc(input bit ft, input bit g1, input bit g2);
    frame_tick = ft;
    goal_p1    = g1;
    goal_p2    = g2;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    goal_p1    = 1'b0;
    goal_p2    = 1'b0;
  endtask

  // POINT -> SERVE -> PLAY takes four frame ticks with both counts at 2
  task automatic to_play(input string t, input logic [17:0] e);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    push(t, e);
  endtask

  task automatic test_reset();
    string t; logic [17:0] e, o;
    rst = 1'b1; frame_tick = 0; start_btn = 1'b1; pause_btn = 0; goal_p1 = 0; goal_p2 = 0;
    repeat (2) @(posedge clk);
    #1;
    push("reset_values", ev(0, 0, 0, 0, 1, 0, 0, 0));
    rst = 1'b0;
    cyc(0, 0, 0);
    push("held_btn_no_edge1", ev(0, 0, 0, 0, 1, 0, 0, 0));
    cyc(0, 0, 0);
    push("held_btn_no_edge2", ev(0, 0, 0, 0, 1, 0, 0, 0));
    cyc(1, 1, 0);
    push("idle_ignores_tick_goal", ev(0, 0, 0, 0, 1, 0, 0, 0));
    start_btn = 1'b0; cyc(0, 0, 0);
    start_btn = 1'b1; cyc(0, 0, 0);
    push("start_to_serve", ev(1, 0, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, o, e);
      end
    end
  endtask

  task automatic test_serve();
    string t; logic [17:0] e, o;
    cyc(1, 0, 0);
    push("serve_tick1", ev(1, 0, 0, 0, 1, 0, 0, 0));
    cyc(0, 1, 0);
    push("serve_goal_ignored", ev(1, 0, 0, 0, 1, 0, 0, 0));
    cyc(1, 0, 0);
    push("serve_to_play", ev(2, 0, 0, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, o, e);
      end
    end
  endtask

  task automatic test_point();
    string t; logic [17:0] e, o;
    cyc(0, 1, 0);
    push("p1_goal", ev(3, 1, 0, 0, 1, 1, 0, 0));
    cyc(1, 0, 0);
    push("point_tick1", ev(3, 1, 0, 0, 1, 1, 0, 0));
    cyc(1, 0, 0);
    push("point_to_serve", ev(1, 1, 0, 0, 1, 1, 0, 0));
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    push("serve_to_play_dir1", ev(2, 1, 0, 1, 0, 1, 0, 0));
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, o, e);
      end
    end
  endtask

  task automatic test_win();
    string t; logic [17:0] e, o;
    cyc(0, 0, 1);
    push("p2_goal1", ev(3, 1, 1, 0, 1, 0, 0, 0));
    to_play("play_1_1", ev(2, 1, 1, 1, 0, 0, 0, 0));
    cyc(0, 0, 1);
    push("p2_goal2", ev(3, 1, 2, 0, 1, 0, 0, 0));
    to_play("play_1_2", ev(2, 1, 2, 1, 0, 0, 0, 0));
    cyc(0, 0, 1);
    push("p2_wins", ev(5, 1, 3, 0, 1, 0, 1, 1));
    cyc(0, 0, 1);
    push("over_goal_ignored", ev(5, 1, 3, 0, 1, 0, 1, 1));
    cyc(1, 0, 0);
    push("over_tick_ignored", ev(5, 1, 3, 0, 1, 0, 1, 1));
    start_btn = 1'b0; cyc(0, 0, 0);
    start_btn = 1'b1; cyc(0, 0, 0);
    push("restart_from_over", ev(1, 0, 0, 0, 1, 0, 0, 1));
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, o, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    string t; logic [17:0] e, o;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    push("play_0_0", ev(2, 0, 0, 1, 0, 0, 0, 1));
    cyc(0, 1, 1);
    push("both_goals", ev(3, 0, 0, 0, 1, 0, 0, 1));
    to_play("play_after_both", ev(2, 0, 0, 1, 0, 0, 0, 1));
    pause_btn = 1'b1;
    cyc(0, 1, 0);
    push("goal_beats_pause", ev(3, 1, 0, 0, 1, 1, 0, 1));
    pause_btn = 1'b0;
    to_play("play_1_0", ev(2, 1, 0, 1, 0, 1, 0, 1));
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, o, e);
      end
    end
  endtask

  task automatic test_pause();
    string t; logic [17:0] e, o;
    pause_btn = 1'b1;
    cyc(0, 0, 0);
    push("pause_enter", ev(4, 1, 0, 0, 0, 1, 0, 1));
    cyc(1, 0, 0);
    push("paused_tick", ev(4, 1, 0, 0, 0, 1, 0, 1));
    cyc(0, 1, 0);
    push("paused_goal_p1", ev(4, 1, 0, 0, 0, 1, 0, 1));
    cyc(0, 0, 1);
    push("paused_goal_p2", ev(4, 1, 0, 0, 0, 1, 0, 1));
    start_btn = 1'b0; cyc(0, 0, 0);
    start_btn = 1'b1; cyc(0, 0, 0);
    push("paused_start_ignored", ev(4, 1, 0, 0, 0, 1, 0, 1));
    pause_btn = 1'b0; cyc(0, 0, 0);
    pause_btn = 1'b1; cyc(0, 0, 0);
    push("pause_resume", ev(2, 1, 0, 1, 0, 1, 0, 1));
    pause_btn = 1'b0;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, o, e);
      end
    end
  endtask

  task automatic test_final_win();
    string t; logic [17:0] e, o;
`ifdef WIN_BY_TWO_EN
    cyc(0, 0, 1);
    push("wb2_1_1", ev(3, 1, 1, 0, 1, 0, 0, 1));
    to_play("wb2_play_1_1", ev(2, 1, 1, 1, 0, 0, 0, 1));
    cyc(0, 1, 0);
    to_play("wb2_play_2_1", ev(2, 2, 1, 1, 0, 1, 0, 1));
    cyc(0, 0, 1);
    to_play("wb2_play_2_2", ev(2, 2, 2, 1, 0, 0, 0, 1));
    cyc(0, 1, 0);
    push("wb2_3_2_no_win", ev(3, 3, 2, 0, 1, 1, 0, 1));
    to_play("wb2_play_3_2", ev(2, 3, 2, 1, 0, 1, 0, 1));
    cyc(0, 0, 1);
    push("wb2_3_3", ev(3, 3, 3, 0, 1, 0, 0, 1));
    to_play("wb2_play_3_3", ev(2, 3, 3, 1, 0, 0, 0, 1));
    cyc(0, 1, 0);
    push("wb2_4_3_no_win", ev(3, 4, 3, 0, 1, 1, 0, 1));
    to_play("wb2_play_4_3", ev(2, 4, 3, 1, 0, 1, 0, 1));
    cyc(0, 1, 0);
    push("wb2_5_3_win", ev(5, 5, 3, 0, 1, 1, 1, 0));
`else
    cyc(0, 1, 0);
    push("p1_goal_2_0", ev(3, 2, 0, 0, 1, 1, 0, 1));
    to_play("play_2_0", ev(2, 2, 0, 1, 0, 1, 0, 1));
    cyc(0, 1, 0);
    push("p1_wins", ev(5, 3, 0, 0, 1, 1, 1, 0));
`endif
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    string t; logic [17:0] e, o;
    start_btn = 1'b0; cyc(0, 0, 0);
    start_btn = 1'b1; cyc(0, 0, 0);
    push("restart_serve", ev(1, 0, 0, 0, 1, 0, 0, 0));
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    push("restart_play", ev(2, 0, 0, 1, 0, 0, 0, 0));
    #3;
    rst = 1'b1;
    #1;
    push("async_reset_mid_play", ev(0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0);
    push("post_reset_held_start", ev(0, 0, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point();
    test_win();
    test_simultaneous();
    test_pause();
    test_final_win();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
